// File: rtl/wb_spi_tx_fifo.sv
// Wishbone-slave byte FIFO drained by a mode-0 SPI shifter onto three project pins.
// Pin output enables follow the project's active select.
module wb_spi_tx_fifo #(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [7:0]  DIV_RESET  = 8'd3
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        active,
   output logic        spi_sclk,
   output logic        spi_mosi,
   output logic        spi_cs_n,
   output logic [2:0]  spi_oeb
);

   localparam int         AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0] DEPTH_C    = 5'(FIFO_DEPTH);
   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_TXDATA = 8'h08;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOW = 2'd1, ST_HIGH = 2'd2} state_t;

   logic          ack_r, en_r, ovf_r;
   logic [31:0]   dat_r;
   logic [7:0]    div_r;
   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [4:0]    count_r;
   state_t        state_r;
   logic [7:0]    hcnt_r, hdiv_r, sh_r;
   logic [2:0]    idx_r;
   logic          sclk_r, mosi_r, cs_n_r;
   logic [2:0]    oeb_r;

   logic          acc_s, wr_s, rd_s, empty_s, full_s, busy_s, go_s, pop_s;
   logic          push_req_s, push_s, ovf_set_s, ovf_clr_s;
   logic [7:0]    off_s, head_s;
   logic [31:0]   rdata_s;
   logic          unused_s;

   assign acc_s      = wbs_stb_i & wbs_cyc_i & ~ack_r & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign off_s      = wbs_adr_i[7:0];
   assign wr_s       = acc_s & wbs_we_i;
   assign rd_s       = acc_s & ~wbs_we_i;
   assign empty_s    = (count_r == 5'd0);
   assign full_s     = (count_r == DEPTH_C);
   assign busy_s     = (state_r != ST_IDLE);
   assign go_s       = en_r & active & ~empty_s;
   assign head_s     = mem_r[rd_ptr_r];
   assign push_req_s = wr_s & (off_s == OFF_TXDATA) & wbs_sel_i[0];
   assign ovf_clr_s  = wr_s & (off_s == OFF_STATUS) & wbs_sel_i[1] & wbs_dat_i[11];
   assign unused_s   = &{1'b0, wbs_sel_i[3:2], wbs_dat_i[31:16]};

   // Pop decision: a new byte starts from idle, or chains off the final half period.
   always_comb begin
      pop_s = 1'b0;
      if ((state_r == ST_IDLE) || ((state_r == ST_HIGH) && (hcnt_r == 8'd0) && (idx_r == 3'd0))) begin
         pop_s = go_s;
      end else begin
         pop_s = 1'b0;
      end
   end

   // Push acceptance; a simultaneous pop frees the slot of a full FIFO.
   always_comb begin
      push_s    = 1'b0;
      ovf_set_s = 1'b0;
      if (push_req_s && full_s && !pop_s) begin
         ovf_set_s = 1'b1;
      end else begin
         push_s = push_req_s;
      end
   end

   // Register read mux.
   always_comb begin
      rdata_s = 32'd0;
      case (off_s)
         OFF_CTRL:   rdata_s = {16'd0, div_r, 7'd0, en_r};
         OFF_STATUS: rdata_s = {20'd0, ovf_r, busy_s, full_s, empty_s, 3'd0, count_r};
         default:    rdata_s = 32'd0;
      endcase
   end

   // Wishbone response and control/status registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_r <= 1'b0;
         dat_r <= 32'd0;
         en_r  <= 1'b0;
         div_r <= DIV_RESET;
         ovf_r <= 1'b0;
         oeb_r <= 3'b111;
      end else begin
         ack_r <= acc_s;
         dat_r <= rd_s ? rdata_s : 32'd0;
         oeb_r <= active ? 3'b000 : 3'b111;
         if (wr_s && (off_s == OFF_CTRL)) begin
            if (wbs_sel_i[0]) en_r <= wbs_dat_i[0];
            else              en_r <= en_r;
            if (wbs_sel_i[1]) div_r <= wbs_dat_i[15:8];
            else              div_r <= div_r;
         end else begin
            en_r  <= en_r;
            div_r <= div_r;
         end
         if (ovf_set_s)      ovf_r <= 1'b1;
         else if (ovf_clr_s) ovf_r <= 1'b0;
         else                ovf_r <= ovf_r;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge wb_clk_i) begin
      if (push_s) mem_r[wr_ptr_r] <= wbs_dat_i[7:0];
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= 5'd0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 5'd1;
            2'b01:   count_r <= count_r - 5'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Mode-0 shift FSM; hcnt counts down the H = div+1 cycles of each half period.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r <= ST_IDLE;
         hcnt_r  <= 8'd0;
         hdiv_r  <= 8'd0;
         sh_r    <= 8'd0;
         idx_r   <= 3'd0;
         sclk_r  <= 1'b0;
         mosi_r  <= 1'b0;
         cs_n_r  <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  sh_r    <= head_s;
                  mosi_r  <= head_s[7];
                  cs_n_r  <= 1'b0;
                  idx_r   <= 3'd7;
                  hdiv_r  <= div_r;
                  hcnt_r  <= div_r;
                  state_r <= ST_LOW;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOW: begin
               if (hcnt_r == 8'd0) begin
                  sclk_r  <= 1'b1;
                  hcnt_r  <= hdiv_r;
                  state_r <= ST_HIGH;
               end else begin
                  hcnt_r  <= hcnt_r - 8'd1;
               end
            end
            ST_HIGH: begin
               if (hcnt_r != 8'd0) begin
                  hcnt_r <= hcnt_r - 8'd1;
               end else if (idx_r != 3'd0) begin
                  sclk_r  <= 1'b0;
                  mosi_r  <= sh_r[6];
                  sh_r    <= {sh_r[6:0], 1'b0};
                  idx_r   <= idx_r - 3'd1;
                  hcnt_r  <= hdiv_r;
                  state_r <= ST_LOW;
               end else if (pop_s) begin
                  sclk_r  <= 1'b0;
                  sh_r    <= head_s;
                  mosi_r  <= head_s[7];
                  idx_r   <= 3'd7;
                  hdiv_r  <= div_r;
                  hcnt_r  <= div_r;
                  state_r <= ST_LOW;
               end else begin
                  sclk_r  <= 1'b0;
                  mosi_r  <= 1'b0;
                  cs_n_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               sclk_r  <= 1'b0;
               mosi_r  <= 1'b0;
               cs_n_r  <= 1'b1;
            end
         endcase
      end
   end

   assign wbs_ack_o = ack_r;
   assign wbs_dat_o = dat_r;
   assign spi_sclk  = sclk_r;
   assign spi_mosi  = mosi_r;
   assign spi_cs_n  = cs_n_r;
   assign spi_oeb   = oeb_r;

endmodule

// File: tb/tb_wb_spi_tx_fifo.sv
// Bench for wb_spi_tx_fifo: register vector table, directed SPI sequences and
// randomized FIFO traffic checked against a queue-based model and a pin monitor.
module tb_wb_spi_tx_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'd0;
   logic [31:0] wdat = 32'd0, adr = 32'd0;
   logic        ack;
   logic [31:0] rdat;
   logic        active = 1'b0;
   logic        sclk, mosi, cs_n;
   logic [2:0]  oeb;

   wb_spi_tx_fifo dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
      .active(active), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n), .spi_oeb(oeb)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] A_CTRL = 32'h3000_0000;
   localparam logic [31:0] A_STAT = 32'h3000_0004;
   localparam logic [31:0] A_TX   = 32'h3000_0008;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   // Pin monitor: bytes sampled on sclk rising edges, cs_n low window lengths.
   logic [7:0] rx_q[$];
   int         win_q[$];
   int         pulse_q[$];
   logic [7:0] sh = 8'd0;
   int         nb = 0, win_len = 0, pulses = 0;
   logic       prev_cs = 1'b1, prev_sclk = 1'b0;

   always @(posedge clk) begin
      #1;
      if (!cs_n) begin
         win_len++;
         if (sclk && !prev_sclk) begin
            sh = {sh[6:0], mosi};
            nb++;
            pulses++;
            if (nb == 8) begin
               rx_q.push_back(sh);
               nb = 0;
            end
         end
      end else if (!prev_cs) begin
         win_q.push_back(win_len);
         pulse_q.push_back(pulses);
         win_len = 0;
         nb = 0;
         pulses = 0;
      end
      prev_cs = cs_n;
      prev_sclk = sclk;
   end

   // One Wishbone access; starts and ends #1 after a clock edge.
   task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd, output bit acked,
                           output int lat, output bit pulse_ok);
      adr = a; we = w; sel = s; wdat = d; stb = 1'b1; cyc = 1'b1;
      acked = 1'b0; rd = 32'd0; lat = 0;
      for (int i = 1; i <= 8 && !acked; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            acked = 1'b1;
            rd = rdat;
            lat = i;
         end
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      pulse_ok = !ack;
   endtask

   task automatic wb_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      logic [31:0] rd; bit ak, po; int lt;
      wb_cycle(a, 1'b1, s, d, rd, ak, lt, po);
      if (!ak) chk("write_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wb_rd(input logic [31:0] a, output logic [31:0] rd);
      bit ak, po; int lt;
      wb_cycle(a, 1'b0, 4'hF, 32'd0, rd, ak, lt, po);
      if (!ak) chk("read_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rx_q.delete(); win_q.delete(); pulse_q.delete();
   endtask

   // Wait for a new cs_n window to close; an expired budget counts as a failure.
   task automatic wait_win(input int n_before, input int budget);
      int t = 0;
      while (win_q.size() <= n_before && t < budget) begin
         @(posedge clk); #1;
         t++;
      end
      if (win_q.size() <= n_before) chk("window_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdat;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[15];

   function automatic logic [31:0] model_status(input int cnt, input bit ovf);
      return {20'd0, ovf, 1'b0, cnt == 8, cnt == 0, 3'd0, 5'(cnt)};
   endfunction

   initial begin
      logic [31:0] rd;
      bit ak, po;
      int lt, nw, div, n;
      logic [7:0] mq[$];
      bit mo;

      tbl[0]  = '{A_STAT,               1'b0, 4'hF, 32'd0,         32'h0000_0100};
      tbl[1]  = '{A_CTRL,               1'b0, 4'hF, 32'd0,         32'h0000_0300};
      tbl[2]  = '{A_TX,                 1'b0, 4'hF, 32'd0,         32'h0000_0000};
      tbl[3]  = '{A_CTRL,               1'b1, 4'b0010, 32'h0000_0501, 32'd0};
      tbl[4]  = '{A_CTRL,               1'b0, 4'hF, 32'd0,         32'h0000_0500};
      tbl[5]  = '{A_CTRL,               1'b1, 4'b0001, 32'h0000_FF01, 32'd0};
      tbl[6]  = '{A_CTRL,               1'b0, 4'hF, 32'd0,         32'h0000_0501};
      tbl[7]  = '{32'h3000_0010,        1'b1, 4'hF, 32'hFFFF_FFFF, 32'd0};
      tbl[8]  = '{32'h3000_0010,        1'b0, 4'hF, 32'd0,         32'h0000_0000};
      tbl[9]  = '{A_TX,                 1'b1, 4'b0000, 32'h0000_0012, 32'd0};
      tbl[10] = '{A_STAT,               1'b0, 4'hF, 32'd0,         32'h0000_0100};
      tbl[11] = '{A_TX,                 1'b1, 4'b0001, 32'h0000_0012, 32'd0};
      tbl[12] = '{A_STAT,               1'b0, 4'hF, 32'd0,         32'h0000_0001};
      tbl[13] = '{A_CTRL,               1'b1, 4'b0011, 32'h0000_0300, 32'd0};
      tbl[14] = '{A_CTRL,               1'b0, 4'hF, 32'd0,         32'h0000_0300};

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_cs_n", {31'd0, cs_n}, 32'd1);
      chk("reset_sclk", {31'd0, sclk}, 32'd0);
      chk("reset_oeb", {29'd0, oeb}, 32'd7);
      chk("reset_ack", {31'd0, ack}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Register access vectors with active low, so nothing drains.
      for (int i = 0; i < 15; i++) begin
         wb_cycle(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].wdat, rd, ak, lt, po);
         chk($sformatf("vec%0d_ack_lat", i), lt, 1);
         chk($sformatf("vec%0d_ack_pulse", i), {31'd0, po}, 32'd1);
         if (!tbl[i].we) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
      end

      // Single byte at div=0.
      do_reset();
      active = 1'b1;
      wb_wr(A_CTRL, 4'b0011, 32'h0000_0001);
      nw = win_q.size();
      wb_wr(A_TX, 4'b0001, 32'h0000_00A5);
      wait_win(nw, 200);
      chk("a5_window", (win_q.size() > nw) ? win_q[nw] : -1, 16);
      chk("a5_pulses", (pulse_q.size() > nw) ? pulse_q[nw] : -1, 8);
      chk("a5_byte", (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'hDEAD, 32'h0000_00A5);
      chk("a5_cs_idle", {31'd0, cs_n}, 32'd1);
      chk("a5_oeb", {29'd0, oeb}, 32'd0);

      // Two bytes back-to-back at div=1.
      rx_q.delete();
      wb_wr(A_CTRL, 4'b0011, 32'h0000_0100);
      wb_wr(A_TX, 4'b0001, 32'h0000_0081);
      wb_wr(A_TX, 4'b0001, 32'h0000_007E);
      nw = win_q.size();
      wb_wr(A_CTRL, 4'b0001, 32'h0000_0001);
      wb_rd(A_STAT, rd);
      chk("b2b_status_mid", rd, 32'h0000_0401);
      repeat (30) @(posedge clk);
      #1;
      wb_rd(A_STAT, rd);
      chk("b2b_status_second", rd, 32'h0000_0500);
      wait_win(nw, 300);
      chk("b2b_window", (win_q.size() > nw) ? win_q[nw] : -1, 64);
      chk("b2b_windows", win_q.size() - nw, 1);
      chk("b2b_byte0", (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'hDEAD, 32'h0000_0081);
      chk("b2b_byte1", (rx_q.size() > 1) ? {24'd0, rx_q[1]} : 32'hDEAD, 32'h0000_007E);
      wb_rd(A_STAT, rd);
      chk("b2b_status_end", rd, 32'h0000_0100);

      // Overflow with the engine disabled.
      wb_wr(A_CTRL, 4'b0001, 32'h0000_0000);
      for (int i = 0; i < 9; i++) wb_wr(A_TX, 4'b0001, 32'(i));
      wb_rd(A_STAT, rd);
      chk("ovf_status", rd, 32'h0000_0A08);
      wb_wr(A_STAT, 4'b0010, 32'h0000_0800);
      wb_rd(A_STAT, rd);
      chk("ovf_cleared", rd, 32'h0000_0208);

      // Inactive project holds off the transfer.
      do_reset();
      active = 1'b0;
      wb_wr(A_CTRL, 4'b0011, 32'h0000_0301);
      nw = win_q.size();
      wb_wr(A_TX, 4'b0001, 32'h0000_0055);
      repeat (20) @(posedge clk);
      #1;
      chk("inact_oeb", {29'd0, oeb}, 32'd7);
      chk("inact_no_window", win_q.size() + (cs_n ? 0 : 100), nw);
      wb_rd(A_STAT, rd);
      chk("inact_status", rd, 32'h0000_0001);
      active = 1'b1;
      @(posedge clk); #1;
      chk("act_oeb", {29'd0, oeb}, 32'd0);
      wait_win(nw, 300);
      chk("act_window", (win_q.size() > nw) ? win_q[nw] : -1, 64);
      chk("act_byte", (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'hDEAD, 32'h0000_0055);

      // Reset during the third bit flushes everything.
      do_reset();
      active = 1'b1;
      wb_wr(A_CTRL, 4'b0011, 32'h0000_0000);
      wb_wr(A_TX, 4'b0001, 32'h0000_00FF);
      wb_wr(A_TX, 4'b0001, 32'h0000_0000);
      wb_wr(A_CTRL, 4'b0011, 32'h0000_0101);
      for (int t = 0; t < 20 && cs_n; t++) begin
         @(posedge clk); #1;
      end
      chk("rst_started", {31'd0, cs_n}, 32'd0);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("rst_sclk", {31'd0, sclk}, 32'd0);
      chk("rst_mosi", {31'd0, mosi}, 32'd0);
      wb_rd(A_STAT, rd);
      chk("rst_status", rd, 32'h0000_0100);
      wb_rd(A_CTRL, rd);
      chk("rst_ctrl", rd, 32'h0000_0300);
      wb_cycle(32'h3000_0100, 1'b0, 4'hF, 32'd0, rd, ak, lt, po);
      chk("nomatch_no_ack", {31'd0, ak}, 32'd0);

      // Randomized fill and drain against a queue model.
      for (int it = 0; it < 6; it++) begin
         do_reset();
         active = 1'b1;
         mq.delete();
         mo = 1'b0;
         div = $urandom_range(0, 3);
         n = $urandom_range(1, 12);
         wb_wr(A_CTRL, 4'b0011, {16'd0, 8'(div), 8'd0});
         for (int k = 0; k < n; k++) begin
            if (k > 0 && $urandom_range(0, 4) == 0) begin
               wb_wr(A_STAT, 4'b0010, 32'h0000_0800);
               mo = 1'b0;
            end else begin
               logic [7:0] b;
               b = 8'($urandom);
               wb_wr(A_TX, 4'b0001, {24'd0, b});
               if (mq.size() < 8) mq.push_back(b);
               else mo = 1'b1;
            end
            wb_rd(A_STAT, rd);
            chk($sformatf("rnd%0d_status%0d", it, k), rd, model_status(mq.size(), mo));
         end
         rx_q.delete();
         nw = win_q.size();
         wb_wr(A_CTRL, 4'b0011, {16'd0, 8'(div), 8'd1});
         wait_win(nw, 16 * 4 * 9 + 100);
         chk($sformatf("rnd%0d_window", it), (win_q.size() > nw) ? win_q[nw] : -1,
             16 * (div + 1) * mq.size());
         chk($sformatf("rnd%0d_nbytes", it), rx_q.size(), mq.size());
         for (int k = 0; k < mq.size() && k < rx_q.size(); k++)
            chk($sformatf("rnd%0d_byte%0d", it, k), {24'd0, rx_q[k]}, {24'd0, mq[k]});
         wb_rd(A_STAT, rd);
         chk($sformatf("rnd%0d_final", it), rd, model_status(0, mo));
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/wb_spi_tx_fifo.md
Name: wb_spi_tx_fifo

Overview:
Wishbone-slave transmit engine that sits directly downstream of the user wrapper, inside a project slot, and consumes that slot's Wishbone and active signals. Firmware writes bytes into a small FIFO. A mode-0 SPI shifter drains the FIFO onto three project IO pins. Pin output enables are gated by the project's active select.

Parameters:
BASE_ADDR, 32'h3000_0000, block base; match on wbs_adr_i[31:8] == BASE_ADDR[31:8]
FIFO_DEPTH, 8, byte entries; power of 2, maximum 16
DIV_RESET, 8'd3, reset value of CTRL.div

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous active-high reset
wbs_stb_i  in  1  WB strobe
wbs_cyc_i  in  1  WB cycle
wbs_we_i  in  1  WB write enable
wbs_sel_i  in  4  WB byte lanes
wbs_dat_i  in  32  WB write data
wbs_adr_i  in  32  WB byte address
wbs_ack_o  out  1  WB acknowledge
wbs_dat_o  out  32  WB read data
active  in  1  project selected; gates IO enables and the start of new bytes
spi_sclk  out  1  serial clock, idles 0
spi_mosi  out  1  serial data, MSB first
spi_cs_n  out  1  chip select, idles 1
spi_oeb  out  3  active-low output enables for {cs_n, mosi, sclk}

Behaviour:
Interface decisions:
- One clock (wb_clk_i).
- Reset wb_rst_i is synchronous and active-high.
- Reset values: ack 0, dat_o 0, sclk 0, mosi 0, cs_n 1, oeb 3'b111, FIFO empty, CTRL = {div=DIV_RESET, en=0}, ovf 0, FSM IDLE.
- Reset asserted mid-byte: abort immediately and flush the FIFO.

Wishbone:
- Access accepted when stb & cyc & !ack & address match.
- ack is high for exactly one cycle, the next cycle. Read data is valid with ack.
- Non-matching address: no ack.
- Unmapped offsets inside the block: reads return 0; writes are ignored; both are acked.
- Register map by offset:
  - 0x00 CTRL (RW): bit0 en; bits[15:8] div. Updated per byte lane (sel[0] -> en, sel[1] -> div).
  - 0x04 STATUS (R): bits[4:0] count; bit8 empty; bit9 full; bit10 busy (FSM != IDLE); bit11 ovf (sticky). Writing 1 to bit11 with sel[1] set clears ovf.
  - 0x08 TXDATA (W): wbs_dat_i[7:0] pushes one byte when sel[0]=1. Reads return 0.

FIFO:
- Push and pop in the same cycle: both take effect; count unchanged.
- Push while full with no simultaneous pop: byte dropped, ovf set. A set and a clear in the same cycle: set wins.
- Pop on empty is impossible by construction.

Shift FSM (H = div+1 cycles per half period; div is sampled at byte load):
- IDLE: if en & active & !empty: pop, cs_n<=0, mosi<=byte[7], bit index 7, go LOW.
- LOW: hold sclk=0 for H cycles, then sclk<=1, go HIGH.
- HIGH: hold sclk=1 for H cycles, then sclk<=0.
  - Index > 0: shift mosi to next bit, decrement index, go LOW.
  - Index = 0, and en & active & !empty: pop next byte, keep cs_n=0, go LOW (back-to-back, no gap).
  - Index = 0 otherwise: cs_n<=1, mosi<=0, go IDLE.
- A byte takes 16*H cycles from cs_n falling to the last sclk falling edge.
- Clearing en or active mid-byte: the current byte completes, then cs_n rises.

Pins:
- spi_oeb = active ? 3'b000 : 3'b111.
- Internal sclk/mosi/cs_n are driven regardless of active.

Test Plan:
1. Reset, then read 0x04 -> dat 0x0000_0100 (empty). Read 0x00 -> 0x0000_0300. ack is a 1-cycle pulse, 1 cycle after stb.
2. active=1, write CTRL=0x0001 (div=0, en=1), write TXDATA=0xA5 -> cs_n low for 16 cycles; 8 sclk pulses of 2 cycles each; mosi sampled on rising edges = 1,0,1,0,0,1,0,1; cs_n returns 1.
3. Queue 0x81 and 0x7E with en=1, div=1 -> single cs_n low window of 64 cycles; STATUS.busy=1 throughout; count reaches 0.
4. en=0, write 9 bytes (depth 8) -> STATUS = count 8, full=1, ovf=1. Write 0x0800 to 0x04 -> ovf=0, count still 8.
5. active=0, en=1, FIFO holds 0x55 -> oeb=3'b111, cs_n stays 1, no pop. Raise active -> transfer starts and oeb=0.
6. Assert wb_rst_i during the 3rd bit of a transfer -> next cycle: cs_n=1, sclk=0, count=0, CTRL back to 0x0300. Access to address 0x3000_0100 -> never acked.
